// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the LRU grant arbiter.
//   - arb_state_t / IDLE / GRANT : FSM state encoding
//   - GRANT_NONE                 : all-ones grant number, sliced to width by users
//   - arb_idx_t / arb_gnum_t     : index / grant-number types for the default
//                                  4-requester configuration
//   Optional feature macro used by the arbiter: ARB_LOCK_EN
// ----------------------------------------------------------------------------
package arb_pkg;

    localparam int unsigned ARB_CANDIDATE_DEF = 4;
    localparam int unsigned ARB_IDX_W_DEF     = $clog2(ARB_CANDIDATE_DEF);

    typedef logic [ARB_IDX_W_DEF-1:0] arb_idx_t;
    typedef logic [ARB_IDX_W_DEF:0]   arb_gnum_t;

    // Wide enough for any practical IDX_W; users slice [IDX_W:0].
    localparam logic [31:0] GRANT_NONE = '1;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t IDLE  = 1'b0;
    localparam arb_state_t GRANT = 1'b1;

endpackage

// File: rtl/priority_rotator.sv
// ----------------------------------------------------------------------------
// priority_rotator
//   Combinational LRU update: the entry at the winner position moves to the
//   lowest-priority slot (CANDIDATE-1); entries behind it move up one slot.
//   Ports:
//     i_perm     : current permutation, [0] = highest priority
//     i_win_pos  : position of the winner inside i_perm
//     o_perm     : rotated permutation
// ----------------------------------------------------------------------------
module priority_rotator
    import arb_pkg::*;
#(
    parameter int unsigned CANDIDATE = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [CANDIDATE-1:0][IDX_W-1:0] i_perm,
    input  logic [IDX_W-1:0]                i_win_pos,
    output logic [CANDIDATE-1:0][IDX_W-1:0] o_perm
);

    always_comb begin
        o_perm = i_perm;
        for (int unsigned p = 0; p < CANDIDATE - 1; p++) begin
            if (IDX_W'(p) >= i_win_pos) begin
                o_perm[p] = i_perm[p+1];
            end
        end
        o_perm[CANDIDATE-1] = i_perm[i_win_pos];
    end

endmodule

// File: rtl/lru_grant_arbiter.sv
// ----------------------------------------------------------------------------
// lru_grant_arbiter
//   Registered N-way arbiter with least-recently-granted priority and a
//   valid/ready grant handshake. One grant outstanding at a time; an accepted
//   grant rotates its owner to lowest priority and re-arbitrates in the same
//   cycle (no bubble between back-to-back grants).
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     request_vec     : bit i = requester i wants the port
//     grant_ready     : downstream accepts the current grant this cycle
//     grant_valid     : grant_number / grant_onehot are valid
//     grant_number    : {1'b0, idx} when valid, all-ones when not
//     grant_onehot    : one-hot of granted idx, zero when not valid
//     priority_array  : current permutation, [0] = highest priority
//     lock_vec        : (ARB_LOCK_EN only) hold the grant after this beat
//   Optional feature macro: ARB_LOCK_EN
// ----------------------------------------------------------------------------
module lru_grant_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned CANDIDATE = 4,
    localparam int unsigned IDX_W     = $clog2(CANDIDATE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CANDIDATE-1:0]            request_vec,
    input  logic                            grant_ready,
`ifdef ARB_LOCK_EN
    input  logic [CANDIDATE-1:0]            lock_vec,
`endif
    output logic                            grant_valid,
    output logic [IDX_W:0]                  grant_number,
    output logic [CANDIDATE-1:0]            grant_onehot,
    output logic [CANDIDATE-1:0][IDX_W-1:0] priority_array
);

    arb_state_t                      r_state;
    logic [CANDIDATE-1:0][IDX_W-1:0] r_perm;
    logic [IDX_W-1:0]                r_win_pos;
    logic [IDX_W-1:0]                r_win_idx;
    logic                            r_valid;
    logic [IDX_W:0]                  r_number;
    logic [CANDIDATE-1:0]            r_onehot;

    arb_state_t                      w_state_n;
    logic [CANDIDATE-1:0][IDX_W-1:0] w_perm_n;
    logic [IDX_W-1:0]                w_win_pos_n;
    logic [IDX_W-1:0]                w_win_idx_n;

    logic [CANDIDATE-1:0][IDX_W-1:0] w_rot_perm;
    logic                            w_cur_found;
    logic [IDX_W-1:0]                w_cur_pos;
    logic                            w_rot_found;
    logic [IDX_W-1:0]                w_rot_pos;
    logic                            w_handshake;
    logic                            w_lock_hold;

    priority_rotator #(
        .CANDIDATE (CANDIDATE),
        .IDX_W     (IDX_W)
    ) u_rotator (
        .i_perm    (r_perm),
        .i_win_pos (r_win_pos),
        .o_perm    (w_rot_perm)
    );

    // Winner search over the current and the post-handshake permutation.
    // Scanning from the back makes the lowest matching position win.
    always_comb begin
        w_cur_found = 1'b0;
        w_cur_pos   = '0;
        w_rot_found = 1'b0;
        w_rot_pos   = '0;
        for (int p = int'(CANDIDATE) - 1; p >= 0; p--) begin
            if (request_vec[r_perm[p]]) begin
                w_cur_found = 1'b1;
                w_cur_pos   = IDX_W'(p);
            end
            if (request_vec[w_rot_perm[p]]) begin
                w_rot_found = 1'b1;
                w_rot_pos   = IDX_W'(p);
            end
        end
    end

    assign w_handshake = (r_state == GRANT) && grant_ready;

`ifdef ARB_LOCK_EN
    assign w_lock_hold = lock_vec[r_win_idx];
`else
    assign w_lock_hold = 1'b0;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_perm_n    = r_perm;
        w_win_pos_n = r_win_pos;
        w_win_idx_n = r_win_idx;
        case (r_state)
            IDLE: begin
                if (w_cur_found) begin
                    w_state_n   = GRANT;
                    w_win_pos_n = w_cur_pos;
                    w_win_idx_n = r_perm[w_cur_pos];
                end
            end
            GRANT: begin
                if (w_handshake) begin
                    if (!w_lock_hold) begin
                        w_perm_n = w_rot_perm;
                        if (w_rot_found) begin
                            w_win_pos_n = w_rot_pos;
                            w_win_idx_n = w_rot_perm[w_rot_pos];
                        end else begin
                            w_state_n = IDLE;
                        end
                    end
                end else if (!request_vec[r_win_idx]) begin
                    // Revoked: the old winner is not requesting, so it cannot
                    // be picked again; priority is left untouched.
                    if (w_cur_found) begin
                        w_win_pos_n = w_cur_pos;
                        w_win_idx_n = r_perm[w_cur_pos];
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_win_pos <= '0;
            r_win_idx <= '0;
            r_valid   <= 1'b0;
            r_number  <= GRANT_NONE[IDX_W:0];
            r_onehot  <= '0;
            for (int unsigned i = 0; i < CANDIDATE; i++) begin
                r_perm[i] <= IDX_W'(i);
            end
        end else begin
            r_state   <= w_state_n;
            r_perm    <= w_perm_n;
            r_win_pos <= w_win_pos_n;
            r_win_idx <= w_win_idx_n;
            r_valid   <= (w_state_n == GRANT);
            if (w_state_n == GRANT) begin
                r_number <= {1'b0, w_win_idx_n};
                r_onehot <= CANDIDATE'(1) << w_win_idx_n;
            end else begin
                r_number <= GRANT_NONE[IDX_W:0];
                r_onehot <= '0;
            end
        end
    end

    assign grant_valid    = r_valid;
    assign grant_number   = r_number;
    assign grant_onehot   = r_onehot;
    assign priority_array = r_perm;

endmodule

// File: tb/tb_lru_grant_arbiter.sv
module tb_lru_grant_arbiter;
    import arb_pkg::*;

    logic            clk;
    logic            rst;
    logic [3:0]      request_vec;
    logic            grant_ready;
    logic [3:0]      lock_vec;
    logic            grant_valid;
    arb_gnum_t       grant_number;
    logic [3:0]      grant_onehot;
    logic [3:0][1:0] priority_array;

    int checks;
    int failures;

    lru_grant_arbiter #(
        .CANDIDATE (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .request_vec    (request_vec),
        .grant_ready    (grant_ready),
`ifdef ARB_LOCK_EN
        .lock_vec       (lock_vec),
`endif
        .grant_valid    (grant_valid),
        .grant_number   (grant_number),
        .grant_onehot   (grant_onehot),
        .priority_array (priority_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [3:0]      req;
        logic            rdy;
        logic            valid;
        logic [2:0]      num;
        logic [3:0]      onehot;
        logic [3:0][1:0] perm;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic logic [3:0][1:0] pa(input int a0, input int a1, input int a2,
                                           input int a3);
        logic [3:0][1:0] r;
        r[0] = 2'(a0);
        r[1] = 2'(a1);
        r[2] = 2'(a2);
        r[3] = 2'(a3);
        return r;
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rd,
                                input logic v, input logic [2:0] n, input logic [3:0] oh,
                                input logic [3:0][1:0] pm);
        vec_t t;
        t.rst = r;  t.req = rq;  t.rdy = rd;
        t.valid = v; t.num = n;  t.onehot = oh; t.perm = pm;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic rd,
                        input logic [3:0] lk);
        rst         = r;
        request_vec = rq;
        grant_ready = rd;
        lock_vec    = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] n,
                              input logic [3:0] oh, input logic [3:0][1:0] pm);
        check({tag, ".valid"},  32'(grant_valid),    32'(v));
        check({tag, ".number"}, 32'(grant_number),   32'(n));
        check({tag, ".onehot"}, 32'(grant_onehot),   32'(oh));
        check({tag, ".perm"},   32'(priority_array), 32'(pm));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // rst req rdy | valid num onehot perm
        vecs[0]  = mk(0, 4'b1010, 0, 1, 3'd1, 4'b0010, pa(0, 1, 2, 3));
        vecs[1]  = mk(0, 4'b1010, 1, 1, 3'd3, 4'b1000, pa(0, 2, 3, 1));
        vecs[2]  = mk(1, 4'b1111, 1, 0, 3'd7, 4'b0000, pa(0, 1, 2, 3));
        vecs[3]  = mk(0, 4'b1111, 1, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        vecs[4]  = mk(0, 4'b1111, 1, 1, 3'd1, 4'b0010, pa(1, 2, 3, 0));
        vecs[5]  = mk(0, 4'b1111, 1, 1, 3'd2, 4'b0100, pa(2, 3, 0, 1));
        vecs[6]  = mk(0, 4'b1111, 1, 1, 3'd3, 4'b1000, pa(3, 0, 1, 2));
        vecs[7]  = mk(0, 4'b1111, 1, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        // Stall: winner 0 keeps requesting, others change.
        vecs[8]  = mk(0, 4'b0001, 0, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        vecs[9]  = mk(0, 4'b1001, 0, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        vecs[10] = mk(0, 4'b0111, 0, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        vecs[11] = mk(0, 4'b1111, 0, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        vecs[12] = mk(0, 4'b0011, 0, 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        // Lone requester wins again after its handshake.
        vecs[13] = mk(0, 4'b0001, 1, 1, 3'd0, 4'b0001, pa(1, 2, 3, 0));
        vecs[14] = mk(0, 4'b0000, 1, 0, 3'd7, 4'b0000, pa(1, 2, 3, 0));
        // Revocation to IDLE.
        vecs[15] = mk(0, 4'b0100, 0, 1, 3'd2, 4'b0100, pa(1, 2, 3, 0));
        vecs[16] = mk(0, 4'b0000, 0, 0, 3'd7, 4'b0000, pa(1, 2, 3, 0));
        vecs[17] = mk(0, 4'b0000, 0, 0, 3'd7, 4'b0000, pa(1, 2, 3, 0));
        // Revocation with another request pending re-arbitrates.
        vecs[18] = mk(0, 4'b0100, 0, 1, 3'd2, 4'b0100, pa(1, 2, 3, 0));
        vecs[19] = mk(0, 4'b1001, 0, 1, 3'd3, 4'b1000, pa(1, 2, 3, 0));
        vecs[20] = mk(0, 4'b0000, 1, 0, 3'd7, 4'b0000, pa(1, 2, 0, 3));

        step(1, 4'b0000, 0, 4'b0000);
        step(1, 4'b0000, 0, 4'b0000);
        expect_out("reset", 0, 3'd7, 4'b0000, pa(0, 1, 2, 3));

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].rdy, 4'b0000);
            expect_out($sformatf("v%0d", i), vecs[i].valid, vecs[i].num, vecs[i].onehot,
                       vecs[i].perm);
        end

        // Reset while a grant is outstanding (and being accepted).
        step(0, 4'b0010, 0, 4'b0000);
        expect_out("rstmid.grant", 1, 3'd1, 4'b0010, pa(1, 2, 0, 3));
        step(1, 4'b1111, 1, 4'b0000);
        expect_out("rstmid.reset", 0, 3'd7, 4'b0000, pa(0, 1, 2, 3));
        step(0, 4'b0000, 0, 4'b0000);
        expect_out("rstmid.after", 0, 3'd7, 4'b0000, pa(0, 1, 2, 3));

`ifdef ARB_LOCK_EN
        // Move 3 off the last slot, then lock it for three beats.
        step(0, 4'b0001, 1, 4'b0000);
        expect_out("lock.pre0", 1, 3'd0, 4'b0001, pa(0, 1, 2, 3));
        step(0, 4'b0000, 1, 4'b0000);
        expect_out("lock.pre1", 0, 3'd7, 4'b0000, pa(1, 2, 3, 0));
        step(0, 4'b1000, 0, 4'b0000);
        expect_out("lock.g0", 1, 3'd3, 4'b1000, pa(1, 2, 3, 0));
        for (int k = 1; k <= 3; k++) begin
            step(0, 4'b1111, 1, 4'b1000);
            expect_out($sformatf("lock.g%0d", k), 1, 3'd3, 4'b1000, pa(1, 2, 3, 0));
        end
        step(0, 4'b1111, 1, 4'b0000);
        expect_out("lock.release", 1, 3'd1, 4'b0010, pa(1, 2, 0, 3));
        // Revocation releases a locked grant without rotating.
        step(0, 4'b0000, 0, 4'b0010);
        expect_out("lock.revoke", 0, 3'd7, 4'b0000, pa(1, 2, 0, 3));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
